// File: rtl/int_to_float_conv.sv
// Iterative signed/unsigned 32/64-bit integer to IEEE-754 single/double converter, one normalization bit per cycle.
// start sampled only in IDLE; done pulses lz+3 cycles later (1 cycle for zero); busy stalls the controller meanwhile.
module int_to_float_conv (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] int_data,
  input  logic        src_width,
  input  logic        is_signed,
  input  logic        fmt,
  output logic        busy,
  output logic        done,
  output logic [63:0] f_result,
  output logic        inexact
);

  typedef enum logic [2:0] {S_IDLE, S_ABS, S_NORM, S_ROUND, S_DONE} state_t;

  state_t      r_state;
  state_t      w_next;

  logic [63:0] r_src;
  logic        r_width;
  logic        r_signed;
  logic        r_fmt;
  logic        r_sign;
  logic [63:0] r_mag;
  logic [5:0]  r_exp;

  logic [63:0] w_ext;
  logic        w_neg;
  logic [63:0] w_abs;

  assign w_ext = r_width  ? r_src :
                 r_signed ? {{32{r_src[31]}}, r_src[31:0]} :
                            {32'h0, r_src[31:0]};
  assign w_neg = r_signed & w_ext[63];
  assign w_abs = w_neg ? (~w_ext + 64'd1) : w_ext;

  // Single rounding: the leading one at mag[63] is implicit.
  logic [22:0] w_sp_m;
  logic        w_sp_g;
  logic        w_sp_s;
  logic        w_sp_up;
  logic [23:0] w_sp_sum;
  logic [7:0]  w_sp_exp;

  assign w_sp_m   = r_mag[62:40];
  assign w_sp_g   = r_mag[39];
  assign w_sp_s   = |r_mag[38:0];
  assign w_sp_up  = w_sp_g & (w_sp_s | w_sp_m[0]);
  assign w_sp_sum = {1'b0, w_sp_m} + {23'h0, w_sp_up};
  assign w_sp_exp = {2'b00, r_exp} + 8'd127 + {7'h0, w_sp_sum[23]};

  logic [51:0] w_dp_m;
  logic        w_dp_g;
  logic        w_dp_s;
  logic        w_dp_up;
  logic [52:0] w_dp_sum;
  logic [10:0] w_dp_exp;

  assign w_dp_m   = r_mag[62:11];
  assign w_dp_g   = r_mag[10];
  assign w_dp_s   = |r_mag[9:0];
  assign w_dp_up  = w_dp_g & (w_dp_s | w_dp_m[0]);
  assign w_dp_sum = {1'b0, w_dp_m} + {52'h0, w_dp_up};
  assign w_dp_exp = {5'h00, r_exp} + 11'd1023 + {10'h0, w_dp_sum[52]};

  logic [63:0] w_res;
  logic        w_inx;

  assign w_res = r_fmt ? {r_sign, w_dp_exp, w_dp_sum[51:0]}
                       : {r_sign, w_sp_exp, w_sp_sum[22:0], 32'h0};
  assign w_inx = r_fmt ? (w_dp_g | w_dp_s) : (w_sp_g | w_sp_s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_ABS;
      S_ABS:   w_next = (w_abs == 64'h0) ? S_DONE : S_NORM;
      S_NORM:  if (r_mag[63]) w_next = S_ROUND;
      S_ROUND: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src    <= 64'h0;
      r_width  <= 1'b0;
      r_signed <= 1'b0;
      r_fmt    <= 1'b0;
      r_sign   <= 1'b0;
      r_mag    <= 64'h0;
      r_exp    <= 6'd0;
      f_result <= 64'h0;
      inexact  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_src    <= int_data;
            r_width  <= src_width;
            r_signed <= is_signed;
            r_fmt    <= fmt;
          end
        end
        S_ABS: begin
          r_sign <= w_neg;
          r_mag  <= w_abs;
          r_exp  <= 6'd63;
          if (w_abs == 64'h0) begin
            f_result <= 64'h0;
            inexact  <= 1'b0;
          end
        end
        S_NORM: begin
          if (!r_mag[63]) begin
            r_mag <= {r_mag[62:0], 1'b0};
            r_exp <= r_exp - 6'd1;
          end
        end
        S_ROUND: begin
          f_result <= w_res;
          inexact  <= w_inx;
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_int_to_float_conv.sv
// Directed-vector bench for int_to_float_conv: results, inexact, latency, handshake, ignored starts and async reset.
module tb_int_to_float_conv;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [63:0] int_data;
  logic        src_width;
  logic        is_signed;
  logic        fmt;
  logic        busy;
  logic        done;
  logic [63:0] f_result;
  logic        inexact;

  int n_cmp = 0;
  int n_err = 0;

  int_to_float_conv dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .int_data  (int_data),
    .src_width (src_width),
    .is_signed (is_signed),
    .fmt       (fmt),
    .busy      (busy),
    .done      (done),
    .f_result  (f_result),
    .inexact   (inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic conv(input string tag, input logic [63:0] d, input logic w, input logic sg,
                      input logic f, input int exp_lat, input logic [63:0] exp_res,
                      input logic exp_inx, input bit poke);
    int lat;
    bit busy_ok;
    @(negedge clk);
    int_data = d; src_width = w; is_signed = sg; fmt = f; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    int_data = 64'h0123_4567_89AB_CDEF; src_width = ~w; is_signed = ~sg; fmt = ~f;
    lat = 0;
    busy_ok = 1;
    for (int n = 1; n <= 200 && lat == 0; n++) begin
      if (!busy) busy_ok = 0;
      if (poke && n == 3) start = 1'b1;
      if (poke && n == 4) start = 1'b0;
      @(posedge clk); #1;
      if (done) lat = n;
    end
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " busy"}, {63'h0, busy_ok & busy}, 64'h1);
    if (poke) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, " done pulse"}, {63'h0, done}, 64'h0);
    chk({tag, " busy fall"}, {63'h0, busy}, 64'h0);
    chk({tag, " result"}, f_result, exp_res);
    chk({tag, " inexact"}, {63'h0, inexact}, {63'h0, exp_inx});
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; int_data = 64'h0;
    src_width = 1'b0; is_signed = 1'b0; fmt = 1'b0;
    #1;
    chk("rst busy", {63'h0, busy}, 64'h0);
    chk("rst done", {63'h0, done}, 64'h0);
    chk("rst result", f_result, 64'h0);
    chk("rst inexact", {63'h0, inexact}, 64'h0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    //   tag         data                    w     sg    fmt   lat  result                  inx   poke
    conv("sp 1",     64'h0000_0000_0000_0001, 1'b0, 1'b1, 1'b0, 66, 64'h3F80_0000_0000_0000, 1'b0, 1'b0);
    conv("sp -1",    64'h0000_0000_FFFF_FFFF, 1'b0, 1'b1, 1'b0, 66, 64'hBF80_0000_0000_0000, 1'b0, 1'b0);
    conv("sp u32max",64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 35, 64'h4F80_0000_0000_0000, 1'b1, 1'b0);
    conv("sp tie ev",64'h0000_0000_0100_0001, 1'b0, 1'b0, 1'b0, 42, 64'h4B80_0000_0000_0000, 1'b1, 1'b0);
    conv("sp tie up",64'h0000_0000_0100_0003, 1'b0, 1'b0, 1'b0, 42, 64'h4B80_0002_0000_0000, 1'b1, 1'b0);
    conv("dp min64", 64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b1, 3,  64'hC3E0_0000_0000_0000, 1'b0, 1'b0);
    conv("dp u64max",64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1, 3,  64'h43F0_0000_0000_0000, 1'b1, 1'b0);
    conv("sp zero",  64'hFFFF_FFFF_0000_0000, 1'b0, 1'b1, 1'b0, 1,  64'h0000_0000_0000_0000, 1'b0, 1'b0);
    conv("dp min32", 64'h0000_0000_8000_0000, 1'b0, 1'b1, 1'b1, 35, 64'hC1E0_0000_0000_0000, 1'b0, 1'b0);
    conv("sp min64", 64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b0, 3,  64'hDF00_0000_0000_0000, 1'b0, 1'b0);
    conv("dp zero",  64'h0000_0000_0000_0000, 1'b1, 1'b0, 1'b1, 1,  64'h0000_0000_0000_0000, 1'b0, 1'b0);
    conv("sp poke",  64'h0000_0000_0000_0001, 1'b0, 1'b0, 1'b0, 66, 64'h3F80_0000_0000_0000, 1'b0, 1'b1);

    // Abort a conversion in NORM with an off-edge reset.
    @(negedge clk);
    int_data = 64'h1; src_width = 1'b0; is_signed = 1'b1; fmt = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort busy", {63'h0, busy}, 64'h0);
    chk("abort done", {63'h0, done}, 64'h0);
    chk("abort result", f_result, 64'h0);
    chk("abort inexact", {63'h0, inexact}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    conv("dp 3",     64'h0000_0000_0000_0003, 1'b0, 1'b1, 1'b1, 65, 64'h4008_0000_0000_0000, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
